imem_fetch_ctrl: RTL

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch controller for a core with two 4 kB instruction ROMs:
// the main program ROM and a separate interrupt-service ROM. It keeps the
// fetch pc, drives the combinational ROM read, and registers each fetched
// word into a one-entry if_* slot that decode consumes with if_ready.
// The pc steps by 2 for compressed (16-bit) words and by 4 for full words.
//
// Branch redirects flush the slot. A level interrupt in main mode saves the
// pc to epc and switches fetch to address 0 of the ISR ROM. A return pulse
// restores epc. Interrupts do not nest.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   redirect_valid branch/jump redirect request from execute
//   redirect_pc    redirect target (bit 0 forced to 0)
//   irq_req        level interrupt request
//   isr_ret        return-from-ISR pulse
//   if_ready       decode accepts the if_* word this cycle
//   imem_inst      instruction read data for imem_addr / imem_sel_isr
//   imem_addr      byte address into the selected ROM (the pc register)
//   imem_sel_isr   1 selects the ISR ROM
//   if_valid       if_* slot holds an instruction
//   if_inst        registered instruction word
//   if_pc          byte address of if_inst
//   if_is_isr      if_inst came from the ISR ROM
//   if_compressed  if_inst is a 16-bit encoding
//   irq_ack        one-cycle pulse in the ISR-entry cycle
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int PC_ADDR_BITS = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [PC_ADDR_BITS-1:0] redirect_pc,
    input  logic                    irq_req,
    input  logic                    isr_ret,
    input  logic                    if_ready,
    input  logic [31:0]             imem_inst,
    output logic [PC_ADDR_BITS-1:0] imem_addr,
    output logic                    imem_sel_isr,
    output logic                    if_valid,
    output logic [31:0]             if_inst,
    output logic [PC_ADDR_BITS-1:0] if_pc,
    output logic                    if_is_isr,
    output logic                    if_compressed,
    output logic                    irq_ack
);

    typedef enum logic {
        RUN_MAIN = 1'b0,
        RUN_ISR  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PC_ADDR_BITS-1:0] pc;
    logic [PC_ADDR_BITS-1:0] epc;
    logic [PC_ADDR_BITS-1:0] redirect_tgt;
    logic [PC_ADDR_BITS-1:0] pc_step;
    logic [PC_ADDR_BITS-1:0] pc_seq;
    logic                    advance;
    logic                    take_redirect;
    logic                    take_ret;
    logic                    take_irq;
    logic                    take_fetch;

    // Any encoding whose two low bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [31:0] word);
        return word[1:0] != 2'b11;
    endfunction

    // Redirect targets are halfword aligned; the low bit is dropped here.
    function automatic logic [PC_ADDR_BITS-1:0] align_half(input logic [PC_ADDR_BITS-1:0] addr);
        return addr & ~PC_ADDR_BITS'(1);
    endfunction

    // ---- event decode: one winner per cycle, highest priority first ----
    always_comb begin
        advance       = !if_valid || if_ready;
        take_redirect = redirect_valid;
        // isr_ret outside the ISR carries no meaning and is dropped.
        take_ret      = !take_redirect && isr_ret && (state == RUN_ISR);
        // Entry needs advance so the word sitting in the slot is not lost.
        take_irq      = !take_redirect && !take_ret && (state == RUN_MAIN)
                        && irq_req && advance;
        take_fetch    = !take_redirect && !take_ret && !take_irq && advance;
        redirect_tgt  = align_half(redirect_pc);
        pc_step       = is_compressed(imem_inst) ? PC_ADDR_BITS'(2) : PC_ADDR_BITS'(4);
        // Natural width truncation gives the wrap from the ROM top to 0.
        pc_seq        = pc + pc_step;
    end

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN_MAIN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        state_nxt = state;
        if (take_ret) begin
            state_nxt = RUN_MAIN;
        end else if (take_irq) begin
            state_nxt = RUN_ISR;
        end
    end

    // ---- FSM outputs ----
    // Both are forced low while reset is asserted, even before the first edge.
    always_comb begin
        irq_ack      = take_irq && !rst;
        imem_sel_isr = (state == RUN_ISR) && !rst;
    end

    // ---- pc, epc and if_* slot ----
    // A flush only clears if_valid; the data fields keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            epc       <= '0;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            if_is_isr <= 1'b0;
        end else if (take_redirect) begin
            pc       <= redirect_tgt;
            if_valid <= 1'b0;
        end else if (take_ret) begin
            pc       <= epc;
            if_valid <= 1'b0;
        end else if (take_irq) begin
            epc      <= pc;
            pc       <= '0;
            if_valid <= 1'b0;
        end else if (take_fetch) begin
            if_inst   <= imem_inst;
            if_pc     <= pc;
            if_is_isr <= imem_sel_isr;
            if_valid  <= 1'b1;
            pc        <= pc_seq;
        end
    end

    assign imem_addr     = pc;
    assign if_compressed = is_compressed(if_inst);

endmodule
